// File: rtl/ad_delay_cal_pkg.sv
// Shared types and constants for the IDELAY tap calibration block.
package ad_delay_cal_pkg;

    localparam int unsigned TAP_W   = 5;
    localparam int unsigned TAP_CNT = 32;
    localparam int unsigned LEN_W   = 6;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        DWELL,
        NEXT,
        SEARCH,
        APPLY,
        DONE
    } state_e;

    // Centre of a passing window, rounding toward the lower tap.
    function automatic logic [TAP_W-1:0] center_tap(input logic [TAP_W-1:0] start,
                                                    input logic [LEN_W-1:0] len);
        logic [LEN_W-1:0] half;
        half = (len - LEN_W'(1)) >> 1;
        return start + TAP_W'(half);
    endfunction

endpackage

// File: rtl/ad_delay_cal_window.sv
// Serial longest-run finder over the per-tap pass map; ties keep the earliest run.
module ad_delay_cal_window
    import ad_delay_cal_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             bit_valid_i,
    input  logic             bit_i,
    output logic [TAP_W-1:0] best_start_o,
    output logic [LEN_W-1:0] best_len_o
);

    logic [TAP_W-1:0] idx_q, idx_d;
    logic [TAP_W-1:0] run_start_q, run_start_d;
    logic [LEN_W-1:0] run_len_q, run_len_d;
    logic [TAP_W-1:0] best_start_q, best_start_d;
    logic [LEN_W-1:0] best_len_q, best_len_d;

    always_comb begin
        idx_d        = idx_q;
        run_start_d  = run_start_q;
        run_len_d    = run_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;
        if (clear_i) begin
            idx_d        = '0;
            run_start_d  = '0;
            run_len_d    = '0;
            best_start_d = '0;
            best_len_d   = '0;
        end else if (bit_valid_i) begin
            idx_d = idx_q + TAP_W'(1);
            if (bit_i) begin
                run_len_d = run_len_q + LEN_W'(1);
                if (run_len_q == '0) begin
                    run_start_d = idx_q;
                end
                // Strictly longer only, so an equal later run never displaces the first.
                if (run_len_d > best_len_q) begin
                    best_len_d   = run_len_d;
                    best_start_d = (run_len_q == '0) ? idx_q : run_start_q;
                end
            end else begin
                run_len_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q        <= '0;
            run_start_q  <= '0;
            run_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
        end else begin
            idx_q        <= idx_d;
            run_start_q  <= run_start_d;
            run_len_q    <= run_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
        end
    end

    assign best_start_o = best_start_q;
    assign best_len_o   = best_len_q;

endmodule

// File: rtl/ad_delay_cal.sv
// Sweeps all 32 delay taps against the PN monitor and applies the centre of the widest window.
// Optional AD_DELAY_CAL_ABORT_EN adds cal_abort, which restores the saved tap and flags failure.
module ad_delay_cal
    import ad_delay_cal_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 13,
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter int unsigned DWELL_CYCLES  = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
`ifdef AD_DELAY_CAL_ABORT_EN
    input  logic                        cal_abort,
`endif
    input  logic                        cal_start,
    input  logic                        pn_err,
    input  logic                        pn_oos,
    input  logic                        delay_locked,
    output logic [DATA_WIDTH-1:0]       dld,
    output logic [DATA_WIDTH*TAP_W-1:0] dwdata,
    output logic                        cal_busy,
    output logic                        cal_done,
    output logic                        cal_fail,
    output logic [TAP_W-1:0]            cal_tap,
    output logic [LEN_W-1:0]            cal_width,
    output logic [TAP_CNT-1:0]          cal_map
);

    localparam int unsigned CNT_MAX0 = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
    localparam int unsigned CNT_MAX  = (CNT_MAX0 > TAP_CNT) ? CNT_MAX0 : TAP_CNT;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

    state_e                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [TAP_W-1:0]            tap_q, tap_d;
    logic                        pass_q, pass_d;
    logic [TAP_W-1:0]            restore_q, restore_d;
    logic [TAP_W-1:0]            apply_tap_q, apply_tap_d;
    logic [DATA_WIDTH-1:0]       dld_q, dld_d;
    logic [DATA_WIDTH*TAP_W-1:0] dwdata_q, dwdata_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        fail_q, fail_d;
    logic [TAP_W-1:0]            cal_tap_q, cal_tap_d;
    logic [LEN_W-1:0]            width_q, width_d;
    logic [TAP_CNT-1:0]          map_q, map_d;

    logic             abort_c;
    logic [TAP_W-1:0] apply_tap_c;
    logic [LEN_W-1:0] width_c;
    logic             win_clear_c;
    logic             win_valid_c;
    logic             win_bit_c;
    logic [TAP_W-1:0] win_start;
    logic [LEN_W-1:0] win_len;

`ifdef AD_DELAY_CAL_ABORT_EN
    assign abort_c = cal_abort && (state_q != IDLE) && (state_q != DONE);
`else
    assign abort_c = 1'b0;
`endif

    // An abort forces an empty window so the restore value is loaded and failure reported.
    assign apply_tap_c = abort_c ? restore_q : apply_tap_q;
    assign width_c     = abort_c ? '0 : width_q;

    ad_delay_cal_window u_window (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (win_clear_c),
        .bit_valid_i (win_valid_c),
        .bit_i       (win_bit_c),
        .best_start_o(win_start),
        .best_len_o  (win_len)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tap_d       = tap_q;
        pass_d      = pass_q;
        restore_d   = restore_q;
        apply_tap_d = apply_tap_q;
        dld_d       = '0;
        dwdata_d    = dwdata_q;
        busy_d      = busy_q;
        done_d      = done_q;
        fail_d      = fail_q;
        cal_tap_d   = cal_tap_q;
        width_d     = width_q;
        map_d       = map_q;
        win_clear_c = 1'b0;
        win_valid_c = 1'b0;
        win_bit_c   = 1'b0;

        if (abort_c && (state_q != APPLY)) begin
            state_d     = APPLY;
            apply_tap_d = apply_tap_c;
            width_d     = width_c;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cal_start) begin
                        restore_d   = cal_tap_q;
                        map_d       = '0;
                        done_d      = 1'b0;
                        fail_d      = 1'b0;
                        tap_d       = '0;
                        cnt_d       = '0;
                        busy_d      = 1'b1;
                        win_clear_c = 1'b1;
                        state_d     = LOAD;
                    end
                end
                LOAD: begin
                    if (delay_locked) begin
                        dld_d    = '1;
                        dwdata_d = {DATA_WIDTH{tap_q}};
                        pass_d   = 1'b1;
                        cnt_d    = '0;
                        state_d  = SETTLE;
                    end
                end
                SETTLE: begin
                    if (!delay_locked) begin
                        pass_d = 1'b0;
                    end
                    if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                        cnt_d   = '0;
                        state_d = DWELL;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DWELL: begin
                    if (pn_err || pn_oos || !delay_locked) begin
                        pass_d = 1'b0;
                    end
                    if (cnt_q == CNT_W'(DWELL_CYCLES - 1)) begin
                        cnt_d   = '0;
                        state_d = NEXT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                NEXT: begin
                    map_d[tap_q] = pass_q;
                    if (tap_q == TAP_W'(TAP_CNT - 1)) begin
                        cnt_d   = '0;
                        state_d = SEARCH;
                    end else begin
                        tap_d   = tap_q + TAP_W'(1);
                        state_d = LOAD;
                    end
                end
                SEARCH: begin
                    // One extra cycle after the last bit lets the window result register.
                    if (cnt_q < CNT_W'(TAP_CNT)) begin
                        win_valid_c = 1'b1;
                        win_bit_c   = map_q[cnt_q[TAP_W-1:0]];
                        cnt_d       = cnt_q + CNT_W'(1);
                    end else begin
                        width_d     = win_len;
                        apply_tap_d = (win_len == '0) ? restore_q : center_tap(win_start, win_len);
                        state_d     = APPLY;
                    end
                end
                APPLY: begin
                    apply_tap_d = apply_tap_c;
                    width_d     = width_c;
                    if (delay_locked) begin
                        dld_d     = '1;
                        dwdata_d  = {DATA_WIDTH{apply_tap_c}};
                        cal_tap_d = apply_tap_c;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        if (width_c == '0) begin
                            fail_d = 1'b1;
                        end
                        state_d = DONE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tap_q       <= '0;
            pass_q      <= 1'b0;
            restore_q   <= '0;
            apply_tap_q <= '0;
            dld_q       <= '0;
            dwdata_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            cal_tap_q   <= '0;
            width_q     <= '0;
            map_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tap_q       <= tap_d;
            pass_q      <= pass_d;
            restore_q   <= restore_d;
            apply_tap_q <= apply_tap_d;
            dld_q       <= dld_d;
            dwdata_q    <= dwdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            cal_tap_q   <= cal_tap_d;
            width_q     <= width_d;
            map_q       <= map_d;
        end
    end

    assign dld       = dld_q;
    assign dwdata    = dwdata_q;
    assign cal_busy  = busy_q;
    assign cal_done  = done_q;
    assign cal_fail  = fail_q;
    assign cal_tap   = cal_tap_q;
    assign cal_width = width_q;
    assign cal_map   = map_q;

endmodule

// File: tb/tb_ad_delay_cal.sv
// Scoreboard bench for ad_delay_cal with SETTLE_CYCLES=4, DWELL_CYCLES=8.
module tb_ad_delay_cal;

    localparam int unsigned DW  = 13;
    localparam int unsigned DWW = DW * 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst = 1'b1;
    logic           cal_start = 1'b0;
    logic           pn_err = 1'b0;
    logic           pn_oos = 1'b0;
    logic           delay_locked = 1'b1;
    logic [DW-1:0]  dld;
    logic [DWW-1:0] dwdata;
    logic           cal_busy, cal_done, cal_fail;
    logic [4:0]     cal_tap;
    logic [5:0]     cal_width;
    logic [31:0]    cal_map;
`ifdef AD_DELAY_CAL_ABORT_EN
    logic           cal_abort = 1'b0;
`endif

    ad_delay_cal #(.DATA_WIDTH(DW), .SETTLE_CYCLES(4), .DWELL_CYCLES(8)) dut (
`ifdef AD_DELAY_CAL_ABORT_EN
        .cal_abort   (cal_abort),
`endif
        .clk         (clk),
        .rst         (rst),
        .cal_start   (cal_start),
        .pn_err      (pn_err),
        .pn_oos      (pn_oos),
        .delay_locked(delay_locked),
        .dld         (dld),
        .dwdata      (dwdata),
        .cal_busy    (cal_busy),
        .cal_done    (cal_done),
        .cal_fail    (cal_fail),
        .cal_tap     (cal_tap),
        .cal_width   (cal_width),
        .cal_map     (cal_map)
    );

    typedef struct {
        logic [31:0] map;
        logic [5:0]  width;
        logic [4:0]  tap;
        logic        fail;
        int          cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] pass_mask = 32'h0;
    int          glitch_tap = 99;
    int          gcnt = 0;
    int          cyc = 0;
    int          run_dld_cnt = 0;
    int          total_dld = 0;
    int          exp_sweep_tap = 0;
    logic        busy_prev = 1'b0;
    int          dld_cyc[32];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DWW-1:0] rep(input logic [4:0] t);
        rep = {DW{t}};
    endfunction

    task automatic finish_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out", name);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    // PN monitor model: failing even taps report errors, odd taps report loss of sync.
    always @(negedge clk) begin
        logic [4:0] t;
        logic       fire;
        t    = dwdata[4:0];
        fire = 1'b0;
        if (dld[0] && cal_busy && (int'(t) == glitch_tap)) begin
            gcnt = 8;
        end else if (gcnt > 0) begin
            gcnt--;
            fire = (gcnt == 0);
        end
        pn_err = fire || (cal_busy && !pass_mask[t] && !t[0]);
        pn_oos = cal_busy && !pass_mask[t] && t[0];
    end

    // Monitor: checks every load strobe and pops the scoreboard when a calibration ends.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            busy_prev = 1'b0;
        end else begin
            if (cal_busy && !busy_prev) begin
                run_dld_cnt   = 0;
                exp_sweep_tap = 0;
            end
            if (dld != '0) begin
                chk("dld_pulse", dld, {DW{1'b1}});
                total_dld++;
                run_dld_cnt++;
                if (cal_busy) begin
                    chk("sweep_tap", dwdata, rep(5'(exp_sweep_tap)));
                    dld_cyc[exp_sweep_tap % 32] = cyc;
                    exp_sweep_tap++;
                end
            end
            if (!cal_busy && busy_prev && cal_done) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done with empty scoreboard");
                end else begin
                    e = sb_q.pop_front();
                    chk("cal_map", cal_map, e.map);
                    chk("cal_width", cal_width, e.width);
                    chk("cal_tap", cal_tap, e.tap);
                    chk("cal_fail", cal_fail, e.fail);
                    chk("apply_dld", dld, {DW{1'b1}});
                    chk("apply_dwdata", dwdata, rep(e.tap));
                    if (e.cnt >= 0) chk("dld_count", run_dld_cnt, e.cnt);
                end
            end
            busy_prev = cal_busy;
        end
    end

    task automatic run(input logic [31:0] mask, input exp_t e);
        int n;
        pass_mask = mask;
        sb_q.push_back(e);
        @(negedge clk) cal_start = 1'b1;
        @(negedge clk) cal_start = 1'b0;
        n = 0;
        while (!cal_busy && n < 10) begin @(negedge clk); n++; end
        if (!cal_busy) finish_now("busy_rise");
        n = 0;
        while (cal_busy && n < 3000) begin @(negedge clk); n++; end
        if (cal_busy) finish_now("busy_fall");
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_dld_tap(input int tap);
        int n;
        n = 0;
        @(negedge clk);
        while (!(dld != '0 && cal_busy && int'(dwdata[4:0]) == tap) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) finish_now("wait_dld_tap");
    endtask

    task automatic lock_stall();
        wait_dld_tap(4);
        repeat (12) @(negedge clk);
        delay_locked = 1'b0;
        repeat (20) @(negedge clk);
        delay_locked = 1'b1;
    endtask

    task automatic restart_poke();
        wait_dld_tap(8);
        repeat (5) @(negedge clk);
        cal_start = 1'b1;
        @(negedge clk) cal_start = 1'b0;
    endtask

`ifdef AD_DELAY_CAL_ABORT_EN
    task automatic abort_at(input int tap);
        wait_dld_tap(tap);
        cal_abort = 1'b1;
        @(negedge clk) cal_abort = 1'b0;
    endtask
`endif

    task automatic check_zero(input string tag);
        chk({tag, "_dld"}, dld, '0);
        chk({tag, "_dwdata"}, dwdata, '0);
        chk({tag, "_tap"}, cal_tap, '0);
        chk({tag, "_width"}, cal_width, '0);
        chk({tag, "_map"}, cal_map, '0);
        chk({tag, "_busy"}, cal_busy, '0);
        chk({tag, "_done"}, cal_done, '0);
        chk({tag, "_fail"}, cal_fail, '0);
    endtask

    initial begin
        int d0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run(32'h0000_7FFF, '{32'h0000_7FFF, 6'd15, 5'd7, 1'b0, 33});
        run(32'h0000_0000, '{32'h0000_0000, 6'd0, 5'd7, 1'b1, 33});
        run(32'h001F_FC00, '{32'h001F_FC00, 6'd11, 5'd15, 1'b0, 33});
        fork
            run(32'h0FF0_0078, '{32'h0FF0_0078, 6'd8, 5'd23, 1'b0, 33});
            restart_poke();
        join
        run(32'h0000_3C3C, '{32'h0000_3C3C, 6'd4, 5'd3, 1'b0, 33});
        fork
            run(32'hFFFF_FFFF, '{32'hFFFF_FFFF, 6'd32, 5'd15, 1'b0, 33});
            lock_stall();
        join
        chk("gap_normal", dld_cyc[4] - dld_cyc[3], 14);
        chk("gap_lock_wait", dld_cyc[5] - dld_cyc[4], 33);
        glitch_tap = 12;
        run(32'hFFFF_FFFF, '{32'hFFFF_EFFF, 6'd19, 5'd22, 1'b0, 33});
        glitch_tap = 99;

`ifdef AD_DELAY_CAL_ABORT_EN
        run(32'h0000_01FF, '{32'h0000_01FF, 6'd9, 5'd4, 1'b0, 33});
        fork
            run(32'hFFFF_FFFF, '{32'h0000_01FF, 6'd0, 5'd4, 1'b1, 11});
            abort_at(9);
        join
`endif

        // Reset during the dwell of tap 3 must abandon the sweep silently.
        pass_mask = 32'hFFFF_FFFF;
        @(negedge clk) cal_start = 1'b1;
        @(negedge clk) cal_start = 1'b0;
        wait_dld_tap(3);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero("midrst");
        rst = 1'b0;
        d0 = total_dld;
        repeat (100) @(negedge clk);
        chk("no_dld_after_rst", total_dld - d0, 0);
        chk("sb_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
